// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use bubble insertion ahead of the ALU.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use_stall
);

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              alu_src_q, alu_src_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    // {reg_write, mem_read, mem_write, mem_to_reg}
    logic [3:0]        ctrl_q, ctrl_d;

    logic              ex_hit_rs, wb_hit_rs;
    logic              ex_hit_rt, wb_hit_rt;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_src_q <= 1'b0;
            alu_op_q  <= '0;
            dest_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            alu_src_q <= alu_src_d;
            alu_op_q  <= alu_op_d;
            dest_q    <= dest_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        alu_src_d = alu_src_q;
        alu_op_d  = alu_op_q;
        dest_d    = dest_q;
        ctrl_d    = ctrl_q;
        if (flush || (!stall && load_use_stall)) begin
            valid_d  = 1'b0;
            alu_op_d = '0;
            ctrl_d   = '0;
        end else if (!stall) begin
            valid_d   = id_valid;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            alu_src_d = id_alu_src;
            alu_op_d  = id_alu_op;
            dest_d    = id_reg_dst ? id_rd : id_rt;
            ctrl_d    = {id_reg_write, id_mem_read,
                         id_mem_write, id_mem_to_reg}
                        & {4{id_valid}};
        end
    end

    // Register 0 is hardwired, so a write to it is never forwarded.
    assign ex_hit_rs = exmem_reg_write && (exmem_rd != '0)
                       && (exmem_rd == rs_q);
    assign wb_hit_rs = memwb_reg_write && (memwb_rd != '0)
                       && (memwb_rd == rs_q);
    assign ex_hit_rt = exmem_reg_write && (exmem_rd != '0)
                       && (exmem_rd == rt_q);
    assign wb_hit_rt = memwb_reg_write && (memwb_rd != '0)
                       && (memwb_rd == rt_q);

    assign rs_fwd = ex_hit_rs ? exmem_result :
                    wb_hit_rs ? memwb_data   : rs_data_q;
    assign rt_fwd = ex_hit_rt ? exmem_result :
                    wb_hit_rt ? memwb_data   : rt_data_q;

    assign alu_a         = rs_fwd;
    assign alu_b         = alu_src_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign alu_op        = alu_op_q;
    assign ex_dest       = dest_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q[3] & valid_q;
    assign ex_mem_read   = ctrl_q[2] & valid_q;
    assign ex_mem_write  = ctrl_q[1] & valid_q;
    assign ex_mem_to_reg = ctrl_q[0] & valid_q;

    assign load_use_stall = valid_q && ctrl_q[2] && (dest_q != '0)
                            && id_valid
                            && ((dest_q == id_rs) || (dest_q == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: capture, forwarding, load-use,
// flush/stall priority and asynchronous reset.
module tb_id_ex_stage;

    typedef struct packed {
        logic        bub;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic [31:0] st;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e, o;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    // Expected EX contents for a capture of the current ID inputs,
    // assuming no forwarding match.
    function automatic exp_t model();
        exp_t m;
        m.bub  = 1'b0;
        m.v    = id_valid;
        m.a    = id_rs_data;
        m.st   = id_rt_data;
        m.b    = id_alu_src ? id_imm : id_rt_data;
        m.op   = id_alu_op;
        m.dest = id_reg_dst ? id_rd : id_rt;
        m.rw   = id_reg_write & id_valid;
        m.mr   = id_mem_read & id_valid;
        m.mw   = id_mem_write & id_valid;
        m.m2r  = id_mem_to_reg & id_valid;
        return m;
    endfunction

    function automatic exp_t bubble();
        exp_t m;
        m = '0;
        m.bub = 1'b1;
        return m;
    endfunction

    // Bubble payload fields are don't-care, so they are masked out.
    function automatic exp_t observe(input logic bub);
        exp_t m;
        m.bub  = bub;
        m.v    = ex_valid;
        m.a    = bub ? 32'h0 : alu_a;
        m.b    = bub ? 32'h0 : alu_b;
        m.op   = alu_op;
        m.dest = bub ? 5'h0 : ex_dest;
        m.st   = bub ? 32'h0 : ex_store_data;
        m.rw   = ex_reg_write;
        m.mr   = ex_mem_read;
        m.mw   = ex_mem_write;
        m.m2r  = ex_mem_to_reg;
        return m;
    endfunction

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alu_src = 0; id_reg_dst = 0; id_alu_op = 0;
        id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        #3;
        o = observe(1'b0);
        checks++;
        if (o !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", o, exp_t'(0));
        end
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_lus: got %b want 0", load_use_stall);
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_capture();
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 7; id_reg_dst = 1;
        id_rs_data = 32'h5; id_rt_data = 32'h3; id_alu_op = 4'b0010;
        id_reg_write = 1;
        sb.push_back(model());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL capture_plain: got %h want %h", o, e);
        end
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 9; id_reg_dst = 0;
        id_rs_data = 32'h1234; id_rt_data = 32'h77;
        id_imm = 32'hFFFF_FFF0; id_alu_src = 1; id_alu_op = 4'b0110;
        id_mem_write = 1;
        sb.push_back(model());
        @(negedge clk);
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL capture_imm: got %h want %h", o, e);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 8; id_rt = 9; id_rd = 12; id_reg_dst = 1;
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_alu_op = 4'b0011;
        id_reg_write = 1;
        sb.push_back(model());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL fwd_capture: got %h want %h", o, e);
        end
        idle();
        exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'hAAAA_0000;
        memwb_reg_write = 1; memwb_rd = 8; memwb_data = 32'h1234_5678;
        #1;
        checks++;
        if (alu_a !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL fwd_exmem_prio: got %h want aaaa0000", alu_a);
        end
        exmem_reg_write = 0;
        #1;
        checks++;
        if (alu_a !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fwd_memwb: got %h want 12345678", alu_a);
        end
        memwb_rd = 9;
        #1;
        checks++;
        if ({alu_a, alu_b, ex_store_data}
            !== {32'h11, 32'h1234_5678, 32'h1234_5678}) begin
            errors++;
            $display("FAIL fwd_rt_memwb: got %h %h %h want 11 12345678 12345678",
                     alu_a, alu_b, ex_store_data);
        end
        exmem_reg_write = 1; exmem_rd = 9;
        #1;
        checks++;
        if ({alu_b, ex_store_data} !== {32'hAAAA_0000, 32'hAAAA_0000}) begin
            errors++;
            $display("FAIL fwd_rt_prio: got %h %h want aaaa0000 aaaa0000",
                     alu_b, ex_store_data);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        idle();
        id_valid = 1; id_alu_op = 4'b0001;
        sb.push_back(model());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL r0_capture: got %h want %h", o, e);
        end
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h5A5A_5A5A;
        #1;
        checks++;
        if ({alu_a, alu_b} !== 64'h0) begin
            errors++;
            $display("FAIL r0_no_fwd: got %h %h want 0 0", alu_a, alu_b);
        end
    endtask

    task automatic test_load_use();
        exp_t lw, dep;
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 1; id_rs_data = 32'd100; id_rt = 9;
        id_imm = 32'd4; id_alu_src = 1; id_alu_op = 4'b0010;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        lw = model();
        sb.push_back(lw);
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lw_capture: got %h want %h", o, e);
        end
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 9; id_rt = 2; id_rd = 10; id_reg_dst = 1;
        id_rt_data = 32'h7; id_alu_op = 4'b0110; id_reg_write = 1;
        stall = 1;
        dep = model();
        dep.a = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL lus_assert: got %b want 1", load_use_stall);
        end
        sb.push_back(lw);
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e || load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL lus_hold: got %h lus=%b want %h lus=1",
                     o, load_use_stall, e);
        end
        @(negedge clk);
        stall = 0;
        sb.push_back(bubble());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL lus_bubble: got %h lus=%b want %h lus=0",
                     o, load_use_stall, e);
        end
        @(negedge clk);
        memwb_reg_write = 1; memwb_rd = 9; memwb_data = 32'hDEAD_BEEF;
        sb.push_back(dep);
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lus_forward: got %h want %h", o, e);
        end
    endtask

    task automatic test_flush_stall();
        exp_t y;
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 3; id_rs_data = 32'h30; id_rt = 4;
        id_rt_data = 32'h40; id_rd = 5; id_reg_dst = 1;
        id_alu_op = 4'b0001; id_reg_write = 1; id_mem_write = 1;
        sb.push_back(model());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL fs_fill: got %h want %h", o, e);
        end
        @(negedge clk);
        flush = 1; stall = 1;
        sb.push_back(bubble());
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL flush_over_stall: got %h want %h", o, e);
        end
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 6; id_rs_data = 32'h600; id_rt = 7;
        id_rt_data = 32'h700; id_imm = 32'h8000_0000; id_alu_src = 1;
        id_alu_op = 4'b1010; id_reg_write = 1; id_mem_to_reg = 1;
        y = model();
        sb.push_back(y);
        @(posedge clk); #1;
        e = sb.pop_front(); o = observe(e.bub);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL fs_refill: got %h want %h", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1;
            id_rs_data = $urandom;
            id_rt_data = $urandom;
            id_alu_op = 4'($urandom_range(15, 0));
            id_rd = 5'($urandom_range(31, 1));
            id_reg_dst = 1;
            sb.push_back(y);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.bub);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, o, e);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle();
            id_valid = 1'($urandom_range(1, 0));
            id_rs = 5'($urandom_range(31, 0));
            id_rt = 5'($urandom_range(31, 0));
            id_rd = 5'($urandom_range(31, 0));
            id_rs_data = $urandom;
            id_rt_data = $urandom;
            id_imm = $urandom;
            id_alu_src = 1'($urandom_range(1, 0));
            id_reg_dst = 1'($urandom_range(1, 0));
            id_alu_op = 4'($urandom_range(15, 0));
            id_reg_write = 1'($urandom_range(1, 0));
            id_mem_write = 1'($urandom_range(1, 0));
            id_mem_to_reg = 1'($urandom_range(1, 0));
            sb.push_back(model());
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.bub);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = 2; id_rs_data = 32'h55; id_rt = 11;
        id_alu_op = 4'b0111; id_reg_write = 1; id_mem_read = 1;
        id_mem_to_reg = 1;
        @(negedge clk);
        id_rs = 11;
        #1;
        checks++;
        if ({ex_valid, ex_mem_read, load_use_stall} !== 3'b111) begin
            errors++;
            $display("FAIL rst_prefill: got %b want 111",
                     {ex_valid, ex_mem_read, load_use_stall});
        end
        #1;
        reset_n = 0;
        idle();
        #1;
        o = observe(1'b0);
        checks++;
        if (o !== exp_t'(0) || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %h lus=%b want 0 lus=0",
                     o, load_use_stall);
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_reg0();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined MIPS datapath. It registers decoded operands and control from ID, resolves EX/MEM and MEM/WB data hazards by forwarding, and presents final ALU operands and the 4-bit ALU operation code to the ALU. It detects load-use hazards and inserts bubbles into EX.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register-address width

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- stall  input  1  global hold; stage keeps its contents
- flush  input  1  branch/jump squash; next state is a bubble
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt, id_rd  input  REG_W  decoded register numbers
- id_rs_data, id_rt_data  input  DATA_W  register-file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_alu_src  input  1  1: ALU B = immediate; 0: ALU B = forwarded rt
- id_reg_dst  input  1  1: destination = rd; 0: destination = rt
- id_alu_op  input  4  ALU operation code, passed through unchanged
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  control bits
- exmem_reg_write  input  1  EX/MEM writes a register
- exmem_rd  input  REG_W  EX/MEM destination
- exmem_result  input  DATA_W  EX/MEM ALU result
- memwb_reg_write  input  1  MEM/WB writes a register
- memwb_rd  input  REG_W  MEM/WB destination
- memwb_data  input  DATA_W  MEM/WB write-back data
- ex_valid  output  1  EX holds a real instruction
- alu_a, alu_b  output  DATA_W  final ALU operands
- alu_op  output  4  registered id_alu_op
- ex_store_data  output  DATA_W  forwarded rt value for stores
- ex_dest  output  REG_W  registered destination (rd or rt)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control bits, forced 0 when ex_valid = 0
- load_use_stall  output  1  request for ID/IF to hold one cycle

## Operation
- Reset (reset_n = 0, asynchronous): all registers cleared. ex_valid = 0, alu_op = 0, ex_dest = 0, all control bits 0, stored data/imm/reg numbers 0. Combinational outputs are then alu_a = alu_b = ex_store_data = 0 unless forwarding matches register 0, which is never forwarded. load_use_stall = 0.
- Clock-edge update, in priority order:
  - flush: load a bubble. ex_valid = 0, control bits = 0, alu_op = 0.
  - stall: hold all state.
  - load_use_stall: load a bubble, as for flush.
  - otherwise: capture all id_* fields. ex_valid = id_valid. Control bits = id_* AND id_valid.
- ex_dest = id_reg_dst ? id_rd : id_rt, resolved at capture.
- Forwarding is combinational on the registered rs and rt, evaluated separately for each:
  - Select exmem_result if exmem_reg_write, exmem_rd != 0 and exmem_rd == reg.
  - Otherwise select memwb_data if memwb_reg_write, memwb_rd != 0 and memwb_rd == reg.
  - Otherwise use the registered read data.
  - EX/MEM has priority over MEM/WB.
- alu_a = forwarded rs. ex_store_data = forwarded rt. alu_b = stored alu_src ? stored imm : forwarded rt.
- load_use_stall = ex_valid & ex_mem_read & ex_dest != 0 & id_valid & (ex_dest == id_rs | ex_dest == id_rt). It is combinational.
- No arithmetic is performed. All data paths are exactly DATA_W wide with no extension.

## Timing
- Latency is 1 cycle from ID inputs to registered EX outputs.
- Forwarding and load_use_stall are combinational from current state plus same-cycle inputs, with no extra cycle.
- A load-use hazard costs exactly one bubble. The cycle after the bubble, the load sits in MEM/WB and is forwarded from memwb_data.
- flush together with stall: flush wins and the bubble is loaded.
- stall together with load_use_stall: hold wins. load_use_stall stays asserted and the bubble is inserted on the first unstalled edge.
- reset_n asserted mid-operation clears the stage immediately, independent of clk.

## Test plan
- Reset: drive reset_n = 0 mid-cycle with the stage full → ex_valid = 0, all control bits 0 and alu_op = 0 immediately; load_use_stall = 0.
- Plain capture: id_rs_data = 0x00000005, id_rt_data = 0x00000003, id_alu_op = 4'b0010, id_alu_src = 0, no forwarding matches → next cycle alu_a = 5, alu_b = 3, alu_op = 0010, ex_valid = 1.
- Forward priority: registered rs = 8; exmem_rd = 8 with result 0xAAAA0000 and memwb_rd = 8 with data 0x12345678, both writing → alu_a = 0xAAAA0000. Drop exmem_reg_write → alu_a = 0x12345678.
- Register 0: rs = 0, exmem_rd = 0, exmem_reg_write = 1, exmem_result = 0xFFFFFFFF → alu_a = the registered value, here 0.
- Load-use: EX holds lw to $9 and ID instruction has rs = 9 → load_use_stall = 1. Next edge ex_valid = 0. Following edge the dependent instruction is captured and forwards from memwb_data.
- Flush/stall: flush = 1 with stall = 1 and id_valid = 1 → next cycle ex_valid = 0, ex_reg_write = 0. Stall alone for 3 cycles → outputs unchanged throughout.
